// File: rtl/asic_readback_checker.sv
// asic_readback_checker: snoops ASIC readback and checks DYN+STAT frames.
// Optional: define ASIC_READBACK_BITERR_EN for a mismatching-bit popcount.
module asic_readback_checker #(
  parameter int SIZESRSTAT  = 88,
  parameter int SIZESRDYN   = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sclk_in,
  input  logic                  sel_in,
  input  logic                  miso_in,
  input  logic [SIZESRDYN-1:0]  exp_dyn,
  input  logic [SIZESRSTAT-1:0] exp_stat,
  input  logic                  clr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err_dyn,
  output logic                  err_stat,
  output logic                  len_err,
  output logic                  sticky_err,
  output logic [SIZESRDYN-1:0]  cap_dyn,
  output logic [SIZESRSTAT-1:0] cap_stat,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [6:0]            bit_err_cnt
);

  localparam int TOTAL = SIZESRDYN + SIZESRSTAT;
  localparam logic [7:0] TOTAL_C = 8'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_q, sel_q, miso_q, fill_q;
  logic sclk_s, sel_s, miso_s;
  logic sclk_prev, sel_prev, armed;
  logic sclk_rise, sel_rise, sel_fall;

  logic [TOTAL-1:0] sr_q;
  logic [7:0]       cnt_q;
  logic chk_len, chk_dyn, chk_stat, chk_pass;

  // Synchronizers; fill_q marks when the chains hold real pin values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_q <= '0;
      sel_q  <= '0;
      miso_q <= '0;
      fill_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_in};
      sel_q  <= {sel_q[SYNC_STAGES-2:0], sel_in};
      miso_q <= {miso_q[SYNC_STAGES-2:0], miso_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sel_s  = sel_q[SYNC_STAGES-1];
  assign miso_s = miso_q[SYNC_STAGES-1];

  // Edge history; armed requires a real sel low before a frame may start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_prev <= 1'b0;
      sel_prev  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      sel_prev  <= sel_s;
      armed     <= armed | (fill_q[SYNC_STAGES-1] & ~sel_s);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sel_rise  = sel_s & ~sel_prev & armed;
  assign sel_fall  = ~sel_s & sel_prev;

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and busy.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      IDLE:    if (sel_rise) state_d = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (sel_fall) state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture shift register and saturating bit counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT && sclk_rise && sel_s) begin
      if (cnt_q < TOTAL_C) sr_q <= {sr_q[TOTAL-2:0], miso_s};
      if (cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end
  end

  assign chk_len  = (cnt_q != TOTAL_C);
  assign chk_dyn  = (sr_q[TOTAL-1:SIZESRSTAT] != exp_dyn);
  assign chk_stat = (sr_q[SIZESRSTAT-1:0] != exp_stat);
  assign chk_pass = ~(chk_len | chk_dyn | chk_stat);

  // Frame results, registered at the end of CHECK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      err_dyn  <= 1'b0;
      err_stat <= 1'b0;
      len_err  <= 1'b0;
      cap_dyn  <= '0;
      cap_stat <= '0;
    end else begin
      done <= (state_q == CHECK);
      if (state_q == CHECK) begin
        pass     <= chk_pass;
        err_dyn  <= chk_dyn;
        err_stat <= chk_stat;
        len_err  <= chk_len;
        cap_dyn  <= sr_q[TOTAL-1:SIZESRSTAT];
        cap_stat <= sr_q[SIZESRSTAT-1:0];
      end
    end
  end

  // Saturating counters and sticky flag; clr beats a coincident CHECK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt  <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (clr) begin
      frame_cnt  <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (state_q == CHECK) begin
      if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
      if (!chk_pass && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
      if (!chk_pass) sticky_err <= 1'b1;
    end
  end

`ifdef ASIC_READBACK_BITERR_EN
  logic [TOTAL-1:0] diff;
  logic [6:0]       bit_err_d;

  // Popcount of mismatching bits across the whole frame.
  always_comb begin
    diff      = sr_q ^ {exp_dyn, exp_stat};
    bit_err_d = '0;
    for (int i = 0; i < TOTAL; i++) bit_err_d = bit_err_d + 7'(diff[i]);
  end

  // Bit error count registered with the other results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    bit_err_cnt <= '0;
    else if (state_q == CHECK)  bit_err_cnt <= bit_err_d;
  end
`else
  assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_asic_readback_checker.sv
// tb_asic_readback_checker: directed checks of the readback checker.
// Two instances: default CNT_W and CNT_W=2 for saturation.
`timescale 1ns/1ps
module tb_asic_readback_checker;

  localparam int TOTAL = 104;
  localparam logic [15:0] GD = 16'h4321;
  localparam logic [87:0] GS = 88'hFEDCBA9876543210012345;
`ifdef ASIC_READBACK_BITERR_EN
  localparam logic [6:0] BE1 = 7'd1;
`else
  localparam logic [6:0] BE1 = 7'd0;
`endif

  logic CLK = 1'b0, RST = 1'b1;
  logic sclk_in = 1'b0, sel_in = 1'b1, miso_in = 1'b0, clr = 1'b0;
  logic [15:0] exp_dyn = GD;
  logic [87:0] exp_stat = GS;

  logic busy, done, pass, err_dyn, err_stat, len_err, sticky_err;
  logic [15:0] cap_dyn;
  logic [87:0] cap_stat;
  logic [15:0] frame_cnt, err_cnt;
  logic [6:0]  bit_err_cnt;

  logic busy2, done2, pass2, err_dyn2, err_stat2, len_err2, sticky2;
  logic [15:0] cap_dyn2;
  logic [87:0] cap_stat2;
  logic [1:0]  frame_cnt2, err_cnt2;
  logic [6:0]  bit_err_cnt2;

  int checks = 0, errors = 0, done_seen = 0, lat, d0;
  logic [103:0] good = {GD, GS};
  logic [103:0] sh1;

  asic_readback_checker dut (
    .CLK(CLK), .RST(RST), .sclk_in(sclk_in), .sel_in(sel_in),
    .miso_in(miso_in), .exp_dyn(exp_dyn), .exp_stat(exp_stat),
    .clr(clr), .busy(busy), .done(done), .pass(pass),
    .err_dyn(err_dyn), .err_stat(err_stat), .len_err(len_err),
    .sticky_err(sticky_err), .cap_dyn(cap_dyn), .cap_stat(cap_stat),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .bit_err_cnt(bit_err_cnt)
  );

  asic_readback_checker #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .sclk_in(sclk_in), .sel_in(sel_in),
    .miso_in(miso_in), .exp_dyn(exp_dyn), .exp_stat(exp_stat),
    .clr(clr), .busy(busy2), .done(done2), .pass(pass2),
    .err_dyn(err_dyn2), .err_stat(err_stat2), .len_err(len_err2),
    .sticky_err(sticky2), .cap_dyn(cap_dyn2), .cap_stat(cap_stat2),
    .frame_cnt(frame_cnt2), .err_cnt(err_cnt2),
    .bit_err_cnt(bit_err_cnt2)
  );

  always #31 CLK = ~CLK;

  always @(negedge CLK) if (done === 1'b1) done_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #5; end
  endtask

  task automatic frame_bits(input logic [TOTAL+7:0] fr,
                            input int n, input int half);
    sel_in = 1'b1;
    cyc(half);
    for (int i = 0; i < n; i++) begin
      miso_in = fr[TOTAL+7-i];
      cyc(half);
      sclk_in = 1'b1;
      cyc(half);
      sclk_in = 1'b0;
    end
    cyc(half);
  endtask

  task automatic frame_end(output int l);
    sel_in = 1'b0;
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1 && l < 0) l = i;
    end
    #4;
  endtask

  task automatic test_reset;
    cyc(3);
    checks++; if ({busy, done, pass, err_dyn, err_stat, len_err, sticky_err} !== 7'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {busy, done, pass, err_dyn, err_stat, len_err, sticky_err}); end
    checks++; if ({cap_dyn, cap_stat} !== 104'd0) begin errors++; $display("FAIL reset_cap: got %h expected 0", {cap_dyn, cap_stat}); end
    checks++; if ({frame_cnt, err_cnt, bit_err_cnt} !== 39'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", {frame_cnt, err_cnt, bit_err_cnt}); end
    RST = 1'b0;
    cyc(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel_high_release: busy got %b expected 0", busy); end
    sel_in = 1'b0;
    cyc(10);
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL sel_high_release_done: got %0d expected 0", done_seen); end
  endtask

  task automatic test_good;
    d0 = done_seen;
    frame_bits({good, 8'h00}, 104, 4);
    frame_end(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL good_latency: got %0d expected 4", lat); end
    checks++; if (done_seen !== d0 + 1) begin errors++; $display("FAIL good_done_once: got %0d expected %0d", done_seen - d0, 1); end
    checks++; if ({pass, len_err, err_dyn, err_stat} !== 4'b1000) begin errors++; $display("FAIL good_flags: got %b expected 1000", {pass, len_err, err_dyn, err_stat}); end
    checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL good_cnt: got %0d/%0d expected 1/0", frame_cnt, err_cnt); end
    checks++; if (cap_dyn !== GD || cap_stat !== GS) begin errors++; $display("FAIL good_cap: got %h %h expected %h %h", cap_dyn, cap_stat, GD, GS); end
    checks++; if (bit_err_cnt !== 7'd0) begin errors++; $display("FAIL good_biterr: got %0d expected 0", bit_err_cnt); end
  endtask

  task automatic test_dyn_err;
    frame_bits({16'h4320, GS, 8'h00}, 104, 8);
    frame_end(lat);
    checks++; if ({pass, len_err, err_dyn, err_stat} !== 4'b0010) begin errors++; $display("FAIL dyn_flags: got %b expected 0010", {pass, len_err, err_dyn, err_stat}); end
    checks++; if (frame_cnt !== 16'd2 || err_cnt !== 16'd1) begin errors++; $display("FAIL dyn_cnt: got %0d/%0d expected 2/1", frame_cnt, err_cnt); end
    checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL dyn_sticky: got %b expected 1", sticky_err); end
    checks++; if (cap_dyn !== 16'h4320) begin errors++; $display("FAIL dyn_cap: got %h expected 4320", cap_dyn); end
    checks++; if (bit_err_cnt !== BE1) begin errors++; $display("FAIL dyn_biterr: got %0d expected %0d", bit_err_cnt, BE1); end
  endtask

  task automatic test_length;
    sh1 = good >> 1;
    frame_bits({good, 8'h00}, 103, 4);
    frame_end(lat);
    checks++; if (len_err !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL short_len: got len %b pass %b expected 1 0", len_err, pass); end
    checks++; if ({cap_dyn, cap_stat} !== sh1) begin errors++; $display("FAIL short_cap: got %h expected %h", {cap_dyn, cap_stat}, sh1); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL short_errcnt: got %0d expected 2", err_cnt); end
    frame_bits({good, 8'hFF}, 106, 4);
    frame_end(lat);
    checks++; if ({pass, len_err, err_dyn, err_stat} !== 4'b0100) begin errors++; $display("FAIL long_flags: got %b expected 0100", {pass, len_err, err_dyn, err_stat}); end
    checks++; if ({cap_dyn, cap_stat} !== good) begin errors++; $display("FAIL long_cap: got %h expected %h", {cap_dyn, cap_stat}, good); end
    checks++; if (frame_cnt !== 16'd4 || err_cnt !== 16'd3) begin errors++; $display("FAIL long_cnt: got %0d/%0d expected 4/3", frame_cnt, err_cnt); end
  endtask

  task automatic test_glitch;
    sel_in = 1'b1;
    cyc(3);
    frame_end(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL glitch_done: latency got %0d expected 4", lat); end
    checks++; if (len_err !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL glitch_len: got len %b pass %b expected 1 0", len_err, pass); end
    checks++; if (frame_cnt !== 16'd5 || err_cnt !== 16'd4) begin errors++; $display("FAIL glitch_cnt: got %0d/%0d expected 5/4", frame_cnt, err_cnt); end
  endtask

  task automatic test_rst_mid;
    d0 = done_seen;
    frame_bits({good, 8'h00}, 50, 4);
    RST = 1'b1;
    cyc(2);
    checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_clear: busy %b cnt %0d expected 0 0", busy, frame_cnt); end
    sel_in = 1'b0;
    cyc(2);
    RST = 1'b0;
    cyc(20);
    checks++; if (done_seen !== d0) begin errors++; $display("FAIL rst_mid_nodone: got %0d pulses expected 0", done_seen - d0); end
    checks++; if ({pass, len_err, sticky_err, err_cnt} !== 19'd0) begin errors++; $display("FAIL rst_mid_state: got %h expected 0", {pass, len_err, sticky_err, err_cnt}); end
    frame_bits({good, 8'h00}, 104, 4);
    frame_end(lat);
    checks++; if (pass !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_next: pass %b cnt %0d expected 1 1", pass, frame_cnt); end
    checks++; if (frame_cnt2 !== 2'd1) begin errors++; $display("FAIL rst_mid_dut2: got %0d expected 1", frame_cnt2); end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 3; k++) begin
      frame_bits({good, 8'h00}, 104, 4);
      frame_end(lat);
    end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL sat_wide: got %0d expected 4", frame_cnt); end
    checks++; if (frame_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_narrow: got %0d expected 3", frame_cnt2); end
    checks++; if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL sat_narrow_err: got %0d expected 0", err_cnt2); end
  endtask

  task automatic test_clr_check;
    frame_bits({16'h4320, GS, 8'h00}, 104, 4);
    sel_in = 1'b0;
    cyc(3);
    clr = 1'b1;
    @(posedge CLK); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_done: got %b expected 1", done); end
    checks++; if (pass !== 1'b0 || err_dyn !== 1'b1) begin errors++; $display("FAIL clr_flags: pass %b err_dyn %b expected 0 1", pass, err_dyn); end
    checks++; if ({frame_cnt, err_cnt, sticky_err} !== 33'd0) begin errors++; $display("FAIL clr_cnt: got %h expected 0", {frame_cnt, err_cnt, sticky_err}); end
    checks++; if (frame_cnt2 !== 2'd0) begin errors++; $display("FAIL clr_dut2: got %0d expected 0", frame_cnt2); end
    #4;
    clr = 1'b0;
    cyc(10);
  endtask

  task automatic test_back_to_back;
    d0 = done_seen;
    frame_bits({good, 8'h00}, 104, 4);
    sel_in = 1'b0;
    cyc(4);
    frame_bits({good, 8'h00}, 104, 4);
    frame_end(lat);
    checks++; if (done_seen !== d0 + 2) begin errors++; $display("FAIL b2b_done: got %0d expected 2", done_seen - d0); end
    checks++; if (frame_cnt !== 16'd2 || err_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d expected 2/0", frame_cnt, err_cnt); end
    checks++; if (pass !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL b2b_pass: pass %b len %b expected 1 0", pass, len_err); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_dyn_err();
    test_length();
    test_glitch();
    test_rst_mid();
    test_saturation();
    test_clr_check();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asic_readback_checker.md
Name: asic_readback_checker

Overview:
- Sits downstream of the ASIC bridge. It snoops the serial readback stream (SCLK/SEL/MISO) from the analog ASIC in the CLK domain.
- Rebuilds each DYNCNF+STATCNF frame and compares it against the expected configuration words.
- Keeps pass/fail status, frame counters and error counters for GPIO/debug readout.
- Replaces the purely combinational XOR error outputs with frame-qualified, registered results.

Parameters:
- SIZESRSTAT, 88, static register length in bits.
- SIZESRDYN, 16, dynamic register length in bits.
- CNT_W, 16, width of frame and error counters (saturating).
- SYNC_STAGES, 2, synchronizer depth on sclk_in/sel_in/miso_in (minimum 2).

Ports:
- CLK  input  1  system clock (16 MHz).
- RST  input  1  asynchronous, active-high reset.
- sclk_in  input  1  serial clock as driven to the ASIC (async to CLK).
- sel_in  input  1  frame select, high = frame active.
- miso_in  input  1  readback data from the ASIC.
- exp_dyn  input  SIZESRDYN  expected DYNCNF word, held static during a frame.
- exp_stat  input  SIZESRSTAT  expected STATCNF word, held static during a frame.
- clr  input  1  synchronous clear of counters and sticky flags.
- busy  output  1  frame capture in progress.
- done  output  1  one-CLK pulse when a frame result is valid.
- pass  output  1  last frame matched (length and data).
- err_dyn  output  1  last frame DYN field mismatch.
- err_stat  output  1  last frame STAT field mismatch.
- len_err  output  1  last frame bit count not equal to SIZESRDYN+SIZESRSTAT.
- sticky_err  output  1  any error since reset/clr.
- cap_dyn  output  SIZESRDYN  captured DYN field of last frame.
- cap_stat  output  SIZESRSTAT  captured STAT field of last frame.
- frame_cnt  output  CNT_W  completed frames.
- err_cnt  output  CNT_W  failed frames.
- bit_err_cnt  output  7  mismatching bit count of last frame (optional feature).

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, state IDLE, synchronizers 0.
- Inputs pass through SYNC_STAGES flops. A sclk rising edge is detected on the synchronized sclk (prev 0, now 1). Sampled miso is the synchronized miso at that same cycle.
- Frame layout is MSB-first: bits 0..SIZESRDYN-1 go to DYN[15]..DYN[0], then STAT[87]..STAT[0]. TOTAL = 104.
- Shift register is TOTAL bits, shifting left with the new bit into the LSB. The 8-bit bit counter saturates at 255.
- State IDLE:
  - sync sel rising -> SHIFT.
  - Clear bit counter and shift register.
  - busy = 0.
- State SHIFT:
  - busy = 1.
  - Each sclk rise while sel high: shift if counter < TOTAL. Counter always increments.
  - Bits beyond TOTAL are discarded but still counted.
  - sync sel falling -> CHECK.
  - An sclk edge in the same cycle as sel falling is ignored.
- State CHECK (one cycle) -> IDLE:
  - len_err = (count != TOTAL). On a short frame, the captured fields are right-aligned as shifted.
  - err_dyn = (cap_dyn != exp_dyn); err_stat = (cap_stat != exp_stat).
  - pass = !(len_err | err_dyn | err_stat).
  - cap_* update; done pulses.
  - frame_cnt += 1; err_cnt += 1 if !pass. Both counters saturate at 2^CNT_W-1.
  - sticky_err |= !pass.
- Latency: done asserts SYNC_STAGES+2 CLK cycles after sel_in falls at the pins.
- Result outputs hold until the next CHECK or reset.
- clr: zeroes frame_cnt, err_cnt and sticky_err. Does not affect state or an in-progress capture. If clr and CHECK coincide, clr wins for counters/sticky; result flags still update.
- sel glitch (sync high for under one sclk edge): frame with count 0 -> len_err = 1, counted as failed.
- RST mid-frame: immediate return to IDLE and all reset values. A partial frame produces no done.
- sel high at reset release: not a frame. A sel rising edge is required.

Optional Feature:
- Macro ASIC_READBACK_BITERR_EN.
- Defined: in CHECK, bit_err_cnt = popcount of (captured frame XOR {exp_dyn,exp_stat}), 0..104, registered with the other results.
- Undefined: bit_err_cnt tied to 0 and no popcount logic is synthesized.

Test Plan:
- exp_dyn=16'h4321, exp_stat=88'hFEDCBA9876543210012345; send the same 104 bits at 2 MHz -> done once, pass=1, frame_cnt=1, err_cnt=0, cap_dyn=16'h4321.
- Same expected values; send DYN=16'h4320 at 1 MHz -> err_dyn=1, err_stat=0, pass=0, err_cnt=1, sticky_err=1, bit_err_cnt=1 (with macro).
- Send 103 bits, then 106 bits -> len_err=1 on both frames; for 106 bits cap_* hold the first 104 bits; err_cnt increments by 2.
- Assert RST after 50 bits, release, then send a good frame -> no done for the partial frame; next frame pass=1, frame_cnt=1.
- Preload frame_cnt by running frames with CNT_W=2 -> frame_cnt saturates at 3. clr coincident with CHECK -> counters 0, pass still updated.
- Two back-to-back frames with sel low for 4 CLK cycles -> two done pulses, frame_cnt=2, no lost bits.
